// File: rtl/gate_stim_checker.sv
// Walks every input vector into a 2-input gate, samples its output after SETTLE_CYCLES, scores it against EXP_TRUTH.
// Latency: 2^N_IN*(SETTLE_CYCLES+1) cycles from START to DONE; no backpressure, START only honoured in IDLE/DONE.
// Optional GATE_CHK_STOP_ON_FAIL_EN: end the run on the first mismatch with I frozen at the failing vector.
module gate_stim_checker #(
    parameter int                    N_IN          = 2,
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [(2**N_IN)-1:0]  EXP_TRUTH     = 4'b1000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    output logic [N_IN-1:0] I,
    input  logic            O,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic [N_IN-1:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_ONE     = {{N_IN{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fvec_q, fvec_d;

    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic            finish_run;

    assign mismatch = (O != EXP_TRUTH[vec_q]);
    assign err_next = mismatch ? (err_q + ERR_ONE) : err_q;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign finish_run = mismatch || (vec_q == LAST_VEC);
`else
    assign finish_run = (vec_q == LAST_VEC);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    vec_d   = '0;
                    err_d   = '0;
                    fvec_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Leaving on count==1 holds each vector SETTLE_CYCLES cycles before the sample cycle.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                err_d = err_next;
                if (mismatch && (err_q == '0)) begin
                    fvec_d = vec_q;
                end
                if (finish_run) begin
                    // PASS uses the post-increment count so the last vector is scored.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
        end
    end

    assign I        = vec_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: emulated gate with random truth tables, cycle-accurate trace checks against a run model.
// Honours GATE_CHK_STOP_ON_FAIL_EN in its model when the same macro is set for the build.
module tb_gate_stim_checker;

    localparam int N_IN   = 2;
    localparam int SETTLE = 2;
    localparam int NV     = 4;
    localparam int PER    = SETTLE + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] i_vec;
    logic       o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] fail_vec;

    logic [3:0] exp_tt  = 4'b1000;
    logic [3:0] gate_tt = 4'b1000;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // The gate under test is modelled as an arbitrary truth table.
    assign o = gate_tt[i_vec];

    gate_stim_checker #(
        .N_IN         (N_IN),
        .SETTLE_CYCLES(SETTLE),
        .EXP_TRUTH    (4'b1000)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .I       (i_vec),
        .O       (o),
        .BUSY    (busy),
        .DONE    (done),
        .PASS    (pass),
        .ERR_CNT (err_cnt),
        .FAIL_VEC(fail_vec)
    );

    // Expected outcome of one run for a given gate truth table.
    task automatic model_run(input logic [3:0] tt, output int e_err, output int e_fv,
                             output int e_len, output int e_last);
        e_err  = 0;
        e_fv   = 0;
        e_len  = NV * PER;
        e_last = NV - 1;
        for (int v = 0; v < NV; v++) begin
            if (tt[v] !== exp_tt[v]) begin
                if (e_err == 0) e_fv = v;
                e_err++;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                e_len  = (v + 1) * PER;
                e_last = v;
                break;
`endif
            end
        end
    endtask

    task automatic run_and_check(input logic [3:0] tt, input string tag, input bit hold_start);
        int e_err, e_fv, e_len, e_last;
        gate_tt = tt;
        model_run(tt, e_err, e_fv, e_len, e_last);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int c = 0; c < e_len; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++;
            if ({i_vec, busy, done} !== {2'(c / PER), 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL %s trace c=%0d: got I=%0d BUSY=%b DONE=%b, expected I=%0d BUSY=1 DONE=0",
                         tag, c, i_vec, busy, done, c / PER);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, i_vec, err_cnt, fail_vec, pass} !==
            {1'b1, 1'b0, 2'(e_last), 3'(e_err), 2'(e_fv), (e_err == 0)}) begin
            n_errors++;
            $display("FAIL %s end: got DONE=%b BUSY=%b I=%0d ERR_CNT=%0d FAIL_VEC=%0d PASS=%b, expected DONE=1 BUSY=0 I=%0d ERR_CNT=%0d FAIL_VEC=%0d PASS=%b",
                     tag, done, busy, i_vec, err_cnt, fail_vec, pass, e_last, e_err, e_fv, e_err == 0);
        end
        if (!hold_start) begin
            repeat (3) @(negedge clk);
            n_checks++;
            if ({done, busy, i_vec, err_cnt, fail_vec, pass} !==
                {1'b1, 1'b0, 2'(e_last), 3'(e_err), 2'(e_fv), (e_err == 0)}) begin
                n_errors++;
                $display("FAIL %s hold: got DONE=%b BUSY=%b I=%0d ERR_CNT=%0d FAIL_VEC=%0d PASS=%b",
                         tag, done, busy, i_vec, err_cnt, fail_vec, pass);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({i_vec, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset: got I=%0d BUSY=%b DONE=%b PASS=%b ERR_CNT=%0d FAIL_VEC=%0d, expected all 0",
                     i_vec, busy, done, pass, err_cnt, fail_vec);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({i_vec, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_errors++;
            $display("FAIL idle_hold: got I=%0d BUSY=%b DONE=%b PASS=%b ERR_CNT=%0d FAIL_VEC=%0d, expected all 0",
                     i_vec, busy, done, pass, err_cnt, fail_vec);
        end
    endtask

    task automatic test_fixed_gates();
        run_and_check(4'b1000, "and_gate", 1'b0);
        run_and_check(4'b1110, "or_gate", 1'b0);
        run_and_check(4'b0000, "stuck0", 1'b0);
        run_and_check(4'b1111, "stuck1", 1'b0);
    endtask

    task automatic test_random_gates();
        for (int n = 0; n < 8; n++) begin
            run_and_check(4'($urandom_range(0, 15)), "random_gate", 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        gate_tt = 4'b1110;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * PER) @(negedge clk);
        n_checks++;
        if ({i_vec, busy} !== {2'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL midrun_pre: got I=%0d BUSY=%b, expected I=2 BUSY=1", i_vec, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({i_vec, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: got I=%0d BUSY=%b DONE=%b PASS=%b ERR_CNT=%0d FAIL_VEC=%0d, expected all 0",
                     i_vec, busy, done, pass, err_cnt, fail_vec);
        end
        run_and_check(4'b1000, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_and_check(4'b1110, "start_held", 1'b1);
        // START is still high in DONE: the next edge must restart immediately.
        gate_tt = 4'b1000;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, busy, i_vec, err_cnt, fail_vec, pass} !== {1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL restart: got DONE=%b BUSY=%b I=%0d ERR_CNT=%0d FAIL_VEC=%0d PASS=%b, expected DONE=0 BUSY=1 I=0 ERR_CNT=0 FAIL_VEC=0 PASS=0",
                     done, busy, i_vec, err_cnt, fail_vec, pass);
        end
        repeat (NV * PER) @(negedge clk);
        n_checks++;
        if ({done, busy, i_vec, err_cnt, pass} !== {1'b1, 1'b0, 2'd3, 3'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL restart_end: got DONE=%b BUSY=%b I=%0d ERR_CNT=%0d PASS=%b, expected DONE=1 BUSY=0 I=3 ERR_CNT=0 PASS=1",
                     done, busy, i_vec, err_cnt, pass);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_gates();
        test_random_gates();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
